// File: rtl/hazard_pkg.sv
// ============================================================================
// hazard_pkg : shared encodings and register-match helper for hazard logic
// Rev 1.0
// ============================================================================
`default_nettype none

package hazard_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic [1:0] {
        ST_FLUSH    = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    // x0 is hardwired zero, so it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] a,
                                       input logic [4:0] b,
                                       input logic       we);
        return we && (a != 5'd0) && (a == b);
    endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_detect.sv
// ============================================================================
// hazard_detect : combinational forwarding selects and load-use/branch hazards
// Rev 1.0
// ============================================================================
`default_nettype none

module hazard_detect
    import hazard_pkg::*;
(
    input  logic [4:0] i_rs1_D,
    input  logic [4:0] i_rs2_D,
    input  logic [4:0] i_rs1_E,
    input  logic [4:0] i_rs2_E,
    input  logic [4:0] i_rd_E,
    input  logic [4:0] i_rd_M,
    input  logic [4:0] i_rd_W,
    input  logic       i_reg_wr_en_E,
    input  logic       i_reg_wr_en_M,
    input  logic       i_reg_wr_en_W,
    input  logic       i_load_E,
    input  logic       i_load_M,
    input  logic       i_branch_D,
    output logic       o_fwdA_D,
    output logic       o_fwdB_D,
    output logic [1:0] o_fwdA_E,
    output logic [1:0] o_fwdB_E,
    output logic       o_lw_stall,
    output logic       o_br_stall
);

    logic w_m_alu_wr;

    // A load in M has no result yet, so only ALU results forward from M.
    assign w_m_alu_wr = i_reg_wr_en_M && !i_load_M;

    always_comb begin
        o_fwdA_E = FWD_RF;
        if (reg_match(i_rd_M, i_rs1_E, w_m_alu_wr))
            o_fwdA_E = FWD_M;
        else if (reg_match(i_rd_W, i_rs1_E, i_reg_wr_en_W))
            o_fwdA_E = FWD_W;

        o_fwdB_E = FWD_RF;
        if (reg_match(i_rd_M, i_rs2_E, w_m_alu_wr))
            o_fwdB_E = FWD_M;
        else if (reg_match(i_rd_W, i_rs2_E, i_reg_wr_en_W))
            o_fwdB_E = FWD_W;
    end

    assign o_fwdA_D = reg_match(i_rd_M, i_rs1_D, w_m_alu_wr);
    assign o_fwdB_D = reg_match(i_rd_M, i_rs2_D, w_m_alu_wr);

    assign o_lw_stall = i_load_E &&
                        (reg_match(i_rd_E, i_rs1_D, 1'b1) ||
                         reg_match(i_rd_E, i_rs2_D, 1'b1));

    assign o_br_stall = i_branch_D &&
                        (reg_match(i_rd_E, i_rs1_D, i_reg_wr_en_E) ||
                         reg_match(i_rd_E, i_rs2_D, i_reg_wr_en_E) ||
                         (i_load_M &&
                          (reg_match(i_rd_M, i_rs1_D, 1'b1) ||
                           reg_match(i_rd_M, i_rs2_D, 1'b1))));

endmodule

`default_nettype wire

// File: rtl/hazard_controller.sv
// ============================================================================
// hazard_controller : pipeline sequencer (flush-after-reset, stalls, flushes,
//                     memory-wait timeout, stall-cycle counter)
// Rev 1.0
// ============================================================================
`default_nettype none

module hazard_controller
    import hazard_pkg::*;
#(
    parameter int FLUSH_CYCLES = 3,
    parameter int MEM_TIMEOUT  = 256,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [4:0]       i_rs1_D,
    input  logic [4:0]       i_rs2_D,
    input  logic [4:0]       i_rs1_E,
    input  logic [4:0]       i_rs2_E,
    input  logic [4:0]       i_rd_E,
    input  logic [4:0]       i_rd_M,
    input  logic [4:0]       i_rd_W,
    input  logic             i_reg_wr_en_E,
    input  logic             i_reg_wr_en_M,
    input  logic             i_reg_wr_en_W,
    input  logic             i_load_E,
    input  logic             i_load_M,
    input  logic             i_branch_D,
    input  logic             i_branch_taken_D,
    input  logic             i_dmem_req_M,
    input  logic             i_dmem_ready_M,
    output logic             o_stall_F,
    output logic             o_stall_D,
    output logic             o_stall_E,
    output logic             o_stall_M,
    output logic             o_flush_D,
    output logic             o_flush_E,
    output logic             o_flush_W,
    output logic             o_fwdA_D,
    output logic             o_fwdB_D,
    output logic [1:0]       o_fwdA_E,
    output logic [1:0]       o_fwdB_E,
    output logic             o_mem_timeout,
    output logic [CNT_W-1:0] o_stall_count
);

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int TO_W = $clog2(MEM_TIMEOUT + 1);

    state_t            r_state;
    logic [FC_W-1:0]   r_flush_cnt;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_mem_timeout;
    logic [CNT_W-1:0]  r_stall_count;

    logic w_lw_stall;
    logic w_br_stall;
    logic w_hazard;
    logic w_mem_wait;

    hazard_detect u_detect (
        .i_rs1_D       (i_rs1_D),
        .i_rs2_D       (i_rs2_D),
        .i_rs1_E       (i_rs1_E),
        .i_rs2_E       (i_rs2_E),
        .i_rd_E        (i_rd_E),
        .i_rd_M        (i_rd_M),
        .i_rd_W        (i_rd_W),
        .i_reg_wr_en_E (i_reg_wr_en_E),
        .i_reg_wr_en_M (i_reg_wr_en_M),
        .i_reg_wr_en_W (i_reg_wr_en_W),
        .i_load_E      (i_load_E),
        .i_load_M      (i_load_M),
        .i_branch_D    (i_branch_D),
        .o_fwdA_D      (o_fwdA_D),
        .o_fwdB_D      (o_fwdB_D),
        .o_fwdA_E      (o_fwdA_E),
        .o_fwdB_E      (o_fwdB_E),
        .o_lw_stall    (w_lw_stall),
        .o_br_stall    (w_br_stall)
    );

    assign w_hazard = w_lw_stall || w_br_stall;

    // The miss-detect cycle in RUN already behaves as a wait cycle; the
    // ready cycle in MEM_WAIT already behaves as a RUN cycle.
    assign w_mem_wait = ((r_state == ST_RUN) && i_dmem_req_M && !i_dmem_ready_M) ||
                        ((r_state == ST_MEM_WAIT) && !i_dmem_ready_M);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state       <= ST_FLUSH;
            r_flush_cnt   <= FC_W'(FLUSH_CYCLES - 1);
            r_to_cnt      <= '0;
            r_mem_timeout <= 1'b0;
            r_stall_count <= '0;
        end else begin
            unique case (r_state)
                ST_FLUSH: begin
                    if (r_flush_cnt == '0)
                        r_state <= ST_RUN;
                    else
                        r_flush_cnt <= r_flush_cnt - FC_W'(1);
                end
                ST_RUN: begin
                    if (w_mem_wait)
                        r_state <= ST_MEM_WAIT;
                end
                ST_MEM_WAIT: begin
                    if (i_dmem_ready_M)
                        r_state <= ST_RUN;
                end
                default: r_state <= ST_FLUSH;
            endcase

            if (w_mem_wait) begin
                if (r_to_cnt != TO_W'(MEM_TIMEOUT))
                    r_to_cnt <= r_to_cnt + TO_W'(1);
                if (r_to_cnt >= TO_W'(MEM_TIMEOUT - 1))
                    r_mem_timeout <= 1'b1;
            end else begin
                r_to_cnt <= '0;
            end

            if (o_stall_F && (r_stall_count != {CNT_W{1'b1}}))
                r_stall_count <= r_stall_count + CNT_W'(1);
        end
    end

    always_comb begin
        o_stall_F = 1'b0;
        o_stall_D = 1'b0;
        o_stall_E = 1'b0;
        o_stall_M = 1'b0;
        o_flush_D = 1'b0;
        o_flush_E = 1'b0;
        o_flush_W = 1'b0;
        unique case (r_state)
            ST_FLUSH: begin
                o_flush_D = 1'b1;
                o_flush_E = 1'b1;
                o_flush_W = 1'b1;
            end
            ST_RUN, ST_MEM_WAIT: begin
                if (w_mem_wait) begin
                    // Taken branch stays in D (no flush) and resolves after the wait.
                    o_stall_F = 1'b1;
                    o_stall_D = 1'b1;
                    o_stall_E = 1'b1;
                    o_stall_M = 1'b1;
                    o_flush_W = 1'b1;
                end else begin
                    o_stall_F = w_hazard;
                    o_stall_D = w_hazard;
                    o_flush_E = w_hazard;
                    o_flush_D = i_branch_taken_D && !w_hazard;
                end
            end
            default: begin
                o_flush_D = 1'b1;
                o_flush_E = 1'b1;
                o_flush_W = 1'b1;
            end
        endcase
    end

    assign o_mem_timeout = r_mem_timeout;
    assign o_stall_count = r_stall_count;

endmodule

`default_nettype wire
